thiele_cpu: RTL and testbench

THIELE_CPU -- requirements
Module: thiele_cpu

---
 rtl/thiele_cpu.sv | 193 +++++++++++++++++++
 tb/tb_thiele_cpu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_cpu.sv
// rtl/thiele_cpu.sv - two-phase XOR-logic CPU with oracle/python handshakes; PYEXEC_EN enables opcode 0x14
module thiele_cpu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_data,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic        mem_en,
    output logic        logic_req,
    output logic [31:0] logic_addr,
    input  logic        logic_ack,
    input  logic [31:0] logic_data,
    output logic        py_req,
    output logic [31:0] py_code_addr,
    input  logic        py_ack,
    input  logic [31:0] py_result,
    output logic [31:0] status,
    output logic [31:0] error_code,
    output logic [31:0] cert_addr,
    output logic [31:0] partition_ops,
    output logic [31:0] mdl_ops,
    output logic [31:0] info_gain,
    output logic [31:0] mu
);
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_LOGIC_WAIT, S_PY_WAIT, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, mu_q, mu_d, part_q, part_d, mdl_q, mdl_d;
    logic [31:0] info_q, info_d, cert_q, cert_d, ecode_q, ecode_d, status_q, status_d;
    logic [31:0] laddr_q, laddr_d, paddr_q, paddr_d;
    logic        lreq_q, lreq_d, preq_q, preq_d, ok_q, ok_d, err_q, err_d;

    logic [31:0] reg_file     [0:31];
    logic [31:0] data_mem     [0:255];
    logic [31:0] module_table [0:63];
    logic [31:0] region_table [0:63][0:7];

    logic [7:0]  op, mb, cost;
    logic [4:0]  ra, rb;
    logic [5:0]  pa;
    logic [31:0] rav, rbv, wd_a, wd_b;
    logic        we_a, we_b, dm_we, pnew_we;
    logic        unused_rdata;

    assign op   = instr_q[31:24];
    assign ra   = instr_q[20:16];
    assign pa   = instr_q[21:16];
    assign mb   = instr_q[15:8];
    assign rb   = instr_q[12:8];
    assign cost = instr_q[7:0];
    assign rav  = reg_file[ra];
    assign rbv  = reg_file[rb];

    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
        return n;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    always_comb begin
        state_d = state_q;  pc_d = pc_q;     instr_d = instr_q; mu_d = mu_q;
        part_d  = part_q;   mdl_d = mdl_q;   info_d = info_q;   cert_d = cert_q;
        ecode_d = ecode_q;  laddr_d = laddr_q; paddr_d = paddr_q;
        lreq_d  = lreq_q;   preq_d = preq_q; ok_d = ok_q;       err_d = err_q;
        we_a = 1'b0; we_b = 1'b0; wd_a = '0; wd_b = '0; dm_we = 1'b0; pnew_we = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_d = instr_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 32'd4;
                mu_d    = mu_q + {24'b0, cost};
                case (op)
                    8'h00: ;
                    8'h0A: begin we_a = 1'b1; wd_a = data_mem[mb]; end
                    8'h0B: begin we_a = 1'b1; wd_a = rav ^ rbv; end
                    8'h0C: begin we_a = 1'b1; wd_a = rbv; we_b = 1'b1; wd_b = rav; end
                    8'h07: begin we_b = 1'b1; wd_b = rav; end
                    8'h0D: begin we_a = 1'b1; wd_a = popcount32(rbv); end
                    8'h0E: begin we_a = 1'b1; wd_a = bitrev32(rbv); end
                    8'h0F: begin we_a = 1'b1; wd_a = {31'b0, ^rbv}; end
                    8'h10: begin we_a = 1'b1; wd_a = rav & rbv; end
                    8'h11: dm_we = 1'b1;
                    8'h01: begin pnew_we = 1'b1; part_d = part_q + 32'd1; end
                    8'h05: begin mdl_d = mdl_q + 32'd1; info_d = info_q + {24'b0, cost}; end
                    // pc advances only once the handshake completes
                    8'h13: begin
                        state_d = S_LOGIC_WAIT; pc_d = pc_q;
                        lreq_d  = 1'b1;         laddr_d = rav;
                    end
`ifdef PYEXEC_EN
                    8'h14: begin
                        state_d = S_PY_WAIT; pc_d = pc_q;
                        preq_d  = 1'b1;      paddr_d = {24'b0, mb};
                    end
`endif
                    8'hFF: begin
                        state_d = S_HALTED; pc_d = pc_q; mu_d = mu_q;
                        cert_d  = pc_q;     ok_d = 1'b1;
                    end
                    default: begin
                        state_d = S_HALTED; pc_d = pc_q; mu_d = mu_q;
                        err_d   = 1'b1;     ecode_d = {24'b0, op};
                    end
                endcase
            end
            S_LOGIC_WAIT: if (logic_ack) begin
                lreq_d = 1'b0; we_b = 1'b1; wd_b = logic_data;
                pc_d = pc_q + 32'd4; state_d = S_FETCH;
            end
            S_PY_WAIT: if (py_ack) begin
                preq_d = 1'b0; we_a = 1'b1; wd_a = py_result;
                pc_d = pc_q + 32'd4; state_d = S_FETCH;
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase
        // bit0 halted_ok, bit1 error, bit2 running, bit3 in_wait
        status_d = {28'b0, (state_d == S_LOGIC_WAIT) || (state_d == S_PY_WAIT),
                    state_d != S_HALTED, err_d, ok_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH; pc_q <= '0; instr_q <= '0; mu_q <= '0; part_q <= '0;
            mdl_q <= '0; info_q <= '0; cert_q <= '0; ecode_q <= '0; status_q <= '0;
            laddr_q <= '0; paddr_q <= '0; lreq_q <= 1'b0; preq_q <= 1'b0;
            ok_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state_q <= state_d; pc_q <= pc_d; instr_q <= instr_d; mu_q <= mu_d; part_q <= part_d;
            mdl_q <= mdl_d; info_q <= info_d; cert_q <= cert_d; ecode_q <= ecode_d; status_q <= status_d;
            laddr_q <= laddr_d; paddr_q <= paddr_d; lreq_q <= lreq_d; preq_q <= preq_d;
            ok_q <= ok_d; err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) reg_file[i] <= '0;
            for (int i = 0; i < 256; i++) data_mem[i] <= '0;
            for (int i = 0; i < 64; i++) begin
                module_table[i] <= '0;
                for (int j = 0; j < 8; j++) region_table[i][j] <= '0;
            end
        end else begin
            if (we_a) reg_file[ra] <= wd_a;
            if (we_b) reg_file[rb] <= wd_b;
            if (dm_we) data_mem[mb] <= rav;
            if (pnew_we) begin
                module_table[pa]    <= 32'd1;
                region_table[pa][0] <= {24'b0, mb};
            end
        end
    end

    assign mem_we        = (state_q == S_EXEC) && (op == 8'h11);
    assign mem_en        = mem_we;
    assign mem_addr      = mem_we ? {22'b0, mb, 2'b00} : '0;
    assign mem_wdata     = mem_we ? rav : '0;
    assign unused_rdata  = ^mem_rdata;

    assign pc            = pc_q;
    assign logic_req     = lreq_q;
    assign logic_addr    = laddr_q;
    assign status        = status_q;
    assign error_code    = ecode_q;
    assign cert_addr     = cert_q;
    assign partition_ops = part_q;
    assign mdl_ops       = mdl_q;
    assign info_gain     = info_q;
    assign mu            = mu_q;
`ifdef PYEXEC_EN
    assign py_req        = preq_q;
    assign py_code_addr  = paddr_q;
`else
    logic unused_py;
    assign py_req        = 1'b0;
    assign py_code_addr  = '0;
    assign unused_py     = ^{preq_q, paddr_q};
`endif
endmodule

// File: tb/tb_thiele_cpu.sv
// tb/tb_thiele_cpu.sv - randomized program bench for thiele_cpu against an instruction-level model
module tb_thiele_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_data, pc, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_we, mem_en, logic_req, py_req;
    logic [31:0] logic_addr, py_code_addr;
    logic        logic_ack = 1'b0, py_ack = 1'b0;
    logic [31:0] logic_data = '0, py_result = '0;
    logic [31:0] status, error_code, cert_addr, partition_ops, mdl_ops, info_gain, mu;

    always #5 clk = ~clk;

    logic [31:0] imem [0:63];
    assign instr_data = imem[pc[7:2]];

    thiele_cpu dut (
        .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .pc(pc),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_en(mem_en),
        .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack), .logic_data(logic_data),
        .py_req(py_req), .py_code_addr(py_code_addr), .py_ack(py_ack), .py_result(py_result),
        .status(status), .error_code(error_code), .cert_addr(cert_addr),
        .partition_ops(partition_ops), .mdl_ops(mdl_ops), .info_gain(info_gain), .mu(mu)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // stimulus data and model results
    logic [31:0] or_val [0:63];
    logic [31:0] py_val [0:63];
    logic [31:0] or_addr_exp [$];
    logic [31:0] py_addr_exp [$];
    logic [31:0] st_addr [$];
    logic [31:0] st_data [$];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:255];
    logic [31:0] m_mod [0:63];
    logic [31:0] m_rgn [0:63];
    logic [31:0] m_pc, m_mu, m_part, m_mdl, m_info, m_cert, m_ec, m_status;
    int or_ri, py_ri, st_ri, or_wait, py_wait;
    bit or_hold = 1'b0;
    logic [31:0] last_laddr;

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    function automatic bit is_legal(input logic [7:0] op);
`ifdef PYEXEC_EN
        return op inside {8'h00, 8'h01, 8'h05, 8'h07, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                          8'h0E, 8'h0F, 8'h10, 8'h11, 8'h13, 8'h14};
`else
        return op inside {8'h00, 8'h01, 8'h05, 8'h07, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                          8'h0E, 8'h0F, 8'h10, 8'h11, 8'h13};
`endif
    endfunction

    // oracle responder: random 0..3 cycle latency, one-cycle ack
    always @(negedge clk) begin
        if (!rst_n) begin
            logic_ack = 1'b0; or_ri = 0; or_wait = 2;
        end else if (logic_ack) begin
            logic_ack = 1'b0;
            check("lreq_drop", {31'b0, logic_req}, 32'd0);
        end else if (logic_req && !or_hold) begin
            if (or_wait == 0) begin
                check($sformatf("laddr%0d", or_ri), logic_addr, or_addr_exp[or_ri]);
                last_laddr = logic_addr;
                logic_data = or_val[or_ri];
                or_ri++;
                logic_ack = 1'b1;
                or_wait = $urandom_range(0, 3);
            end else or_wait--;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            py_ack = 1'b0; py_ri = 0; py_wait = 1;
        end else if (py_ack) begin
            py_ack = 1'b0;
            check("preq_drop", {31'b0, py_req}, 32'd0);
        end else if (py_req) begin
            if (py_wait == 0) begin
                check($sformatf("paddr%0d", py_ri), py_code_addr, py_addr_exp[py_ri]);
                py_result = py_val[py_ri];
                py_ri++;
                py_ack = 1'b1;
                py_wait = $urandom_range(0, 3);
            end else py_wait--;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) st_ri = 0;
        else if (mem_we) begin
            check("st_en", {31'b0, mem_en}, 32'd1);
            if (st_ri < st_addr.size()) begin
                check($sformatf("st_addr%0d", st_ri), mem_addr, st_addr[st_ri]);
                check($sformatf("st_data%0d", st_ri), mem_wdata, st_data[st_ri]);
            end
            st_ri++;
        end
    end

    task automatic run_model();
        logic [7:0]  op, a, b, c;
        logic [31:0] t;
        int oi, pi;
        oi = 0; pi = 0;
        m_pc = 0; m_mu = 0; m_part = 0; m_mdl = 0; m_info = 0; m_cert = 0; m_ec = 0; m_status = 0;
        foreach (m_reg[i]) m_reg[i] = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        foreach (m_mod[i]) begin m_mod[i] = 0; m_rgn[i] = 0; end
        or_addr_exp.delete(); py_addr_exp.delete(); st_addr.delete(); st_data.delete();
        for (int step = 0; step < 4096; step++) begin
            {op, a, b, c} = imem[m_pc[7:2]];
            if (op == 8'hFF) begin m_cert = m_pc; m_status = 32'd1; break; end
            if (!is_legal(op)) begin m_ec = {24'b0, op}; m_status = 32'd2; break; end
            case (op)
                8'h0A: m_reg[a[4:0]] = m_mem[b];
                8'h0B: m_reg[a[4:0]] ^= m_reg[b[4:0]];
                8'h0C: begin t = m_reg[a[4:0]]; m_reg[a[4:0]] = m_reg[b[4:0]]; m_reg[b[4:0]] = t; end
                8'h07: m_reg[b[4:0]] = m_reg[a[4:0]];
                8'h0D: m_reg[a[4:0]] = $countones(m_reg[b[4:0]]);
                8'h0E: begin
                    for (int i = 0; i < 32; i++) t[i] = m_reg[b[4:0]][31-i];
                    m_reg[a[4:0]] = t;
                end
                8'h0F: m_reg[a[4:0]] = {31'b0, ^m_reg[b[4:0]]};
                8'h10: m_reg[a[4:0]] &= m_reg[b[4:0]];
                8'h11: begin
                    m_mem[b] = m_reg[a[4:0]];
                    st_addr.push_back({22'b0, b, 2'b00});
                    st_data.push_back(m_reg[a[4:0]]);
                end
                8'h13: begin or_addr_exp.push_back(m_reg[a[4:0]]); m_reg[b[4:0]] = or_val[oi]; oi++; end
                8'h14: begin py_addr_exp.push_back({24'b0, b}); m_reg[a[4:0]] = py_val[pi]; pi++; end
                8'h01: begin m_mod[a[5:0]] = 1; m_rgn[a[5:0]] = {24'b0, b}; m_part++; end
                8'h05: begin m_mdl++; m_info += {24'b0, c}; end
                default: ;
            endcase
            m_mu += {24'b0, c};
            m_pc += 4;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_and_compare(input string tag);
        int cyc;
        run_model();
        do_reset();
        cyc = 0;
        while (!(status[0] || status[1]) && cyc < 4000) begin @(negedge clk); cyc++; end
        check({tag, ":done"}, 32'(cyc < 4000), 32'd1);
        check({tag, ":pc"}, pc, m_pc);
        check({tag, ":mu"}, mu, m_mu);
        check({tag, ":part"}, partition_ops, m_part);
        check({tag, ":mdl"}, mdl_ops, m_mdl);
        check({tag, ":info"}, info_gain, m_info);
        check({tag, ":cert"}, cert_addr, m_cert);
        check({tag, ":ecode"}, error_code, m_ec);
        check({tag, ":status"}, status, m_status);
        check({tag, ":lreq"}, {31'b0, logic_req}, 32'd0);
        check({tag, ":nstores"}, st_ri, st_addr.size());
        check({tag, ":noracle"}, or_ri, or_addr_exp.size());
        for (int i = 0; i < 32; i++) check($sformatf("%s:r%0d", tag, i), dut.reg_file[i], m_reg[i]);
        for (int i = 0; i < 256; i++) check($sformatf("%s:m%0d", tag, i), dut.data_mem[i], m_mem[i]);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("%s:mod%0d", tag, i), dut.module_table[i], m_mod[i]);
            check($sformatf("%s:rgn%0d", tag, i), dut.region_table[i][0], m_rgn[i]);
        end
    endtask

    task automatic clear_imem();
        foreach (imem[i]) imem[i] = 32'h0;
        foreach (or_val[i]) or_val[i] = $urandom;
        foreach (py_val[i]) py_val[i] = $urandom;
    endtask

    task automatic load_p1();
        int k;
        clear_imem();
        or_val[0] = 32'h29; or_val[1] = 32'h12; or_val[2] = 32'h22; or_val[3] = 32'h03;
        or_val[4] = 32'hABCD1234; py_val[0] = 32'h12345678;
        k = 0;
        for (int j = 0; j < 4; j++) begin
            imem[k] = ins(8'h13, 8'd0, 8'd1, 8'd1); k++;
            imem[k] = ins(8'h11, 8'd1, 8'(j), 8'd1); k++;
        end
        for (int j = 0; j < 4; j++) begin imem[k] = ins(8'h0A, 8'(j), 8'(j), 8'd2); k++; end
        imem[k] = ins(8'h0B, 3, 0, 1); k++;  imem[k] = ins(8'h0B, 3, 1, 1); k++;
        imem[k] = ins(8'h0C, 0, 3, 1); k++;  imem[k] = ins(8'h07, 2, 4, 1); k++;
        imem[k] = ins(8'h0D, 5, 4, 1); k++;  imem[k] = ins(8'h0E, 6, 4, 1); k++;
        imem[k] = ins(8'h0F, 7, 0, 1); k++;  imem[k] = ins(8'h10, 1, 2, 1); k++;
        imem[k] = ins(8'h11, 5, 4, 1); k++;  imem[k] = ins(8'h11, 6, 5, 1); k++;
        imem[k] = ins(8'h11, 7, 6, 1); k++;  imem[k] = ins(8'h13, 0, 8, 3); k++;
        imem[k] = ins(8'h14, 9, 8'h5A, 3); k++;
        imem[k] = ins(8'hFF, 0, 0, 0);
    endtask

    logic [7:0] lops [0:12] = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h07, 8'h0D, 8'h0E,
                                8'h0F, 8'h10, 8'h11, 8'h13, 8'h01, 8'h05};

    initial begin
        logic [7:0] bad;
        int cyc;

        // reset state
        clear_imem();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_lreq", {31'b0, logic_req}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);

        // fixed program: XOR ops, stores, oracle, python
        load_p1();
        run_and_compare("p1");
        check("p1_r0", dut.reg_file[0], 32'h38);
        check("p1_r1", dut.reg_file[1], 32'h02);
        check("p1_r3", dut.reg_file[3], 32'h29);
        check("p1_r4", dut.reg_file[4], 32'h22);
        check("p1_r5", dut.reg_file[5], 32'd2);
        check("p1_r6", dut.reg_file[6], 32'h44000000);
        check("p1_r7", dut.reg_file[7], 32'd1);
        check("p1_m4", dut.data_mem[4], 32'd2);
        check("p1_m5", dut.data_mem[5], 32'h44000000);
        check("p1_m6", dut.data_mem[6], 32'd1);
        check("p1_r8", dut.reg_file[8], 32'hABCD1234);
        check("p1_laddr", last_laddr, 32'h38);
`ifdef PYEXEC_EN
        check("p1_r9", dut.reg_file[9], 32'h12345678);
        check("p1_halt", {31'b0, status[0]}, 32'd1);
`else
        check("p1_ec14", error_code, 32'h14);
        check("p1_err", {31'b0, status[1]}, 32'd1);
`endif

        // illegal opcode at pc 0
        clear_imem();
        imem[0] = ins(8'h77, 8'h12, 8'h34, 8'h00);
        run_and_compare("ill");
        check("ill_ec", error_code, 32'h77);
        check("ill_st1", {31'b0, status[1]}, 32'd1);
        check("ill_pc", pc, 32'd0);

        // NOPs with cost then HALT
        clear_imem();
        for (int i = 0; i < 3; i++) imem[i] = ins(8'h00, 0, 0, 8'd5);
        imem[3] = ins(8'hFF, 0, 0, 0);
        run_and_compare("nop");
        check("nop_mu", mu, 32'd15);
        check("nop_pc", pc, 32'h0C);
        check("nop_cert", cert_addr, 32'h0C);

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            clear_imem();
            for (int i = 0; i < 12; i++) imem[i] = ins(8'h13, 8'($urandom), 8'($urandom), 8'($urandom));
            for (int i = 12; i < 52; i++)
                imem[i] = ins(lops[$urandom_range(0, 12)], 8'($urandom), 8'($urandom), 8'($urandom));
            if (p % 2 == 0) imem[52] = ins(8'hFF, 0, 0, 0);
            else begin
                do bad = 8'($urandom); while (is_legal(bad) || bad == 8'hFF || bad == 8'h14);
                imem[52] = ins(bad, 0, 0, 0);
            end
            run_and_compare($sformatf("rnd%0d", p));
        end

        // reset asserted mid-run clears everything at the next edge
        load_p1();
        run_model();
        do_reset();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_pc", pc, 32'd0);
        check("mid_mu", mu, 32'd0);
        check("mid_status", status, 32'd0);
        check("mid_part", partition_ops, 32'd0);
        check("mid_cert", cert_addr, 32'd0);
        check("mid_lreq", {31'b0, logic_req}, 32'd0);
        check("mid_laddr", logic_addr, 32'd0);
        check("mid_preq", {31'b0, py_req}, 32'd0);
        check("mid_mem_we", {31'b0, mem_we}, 32'd0);
        check("mid_r0", dut.reg_file[0], 32'd0);
        check("mid_m0", dut.data_mem[0], 32'd0);

        // reset while waiting on the oracle drops the request without a write
        clear_imem();
        imem[0] = ins(8'h13, 8'd0, 8'd3, 8'd1);
        imem[1] = ins(8'hFF, 0, 0, 0);
        run_model();
        or_hold = 1'b1;
        do_reset();
        cyc = 0;
        while (!logic_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("wait_req_seen", {31'b0, logic_req}, 32'd1);
        check("wait_status", status, 32'd12);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("wait_rst_lreq", {31'b0, logic_req}, 32'd0);
        check("wait_rst_r3", dut.reg_file[3], 32'd0);
        check("wait_rst_pc", pc, 32'd0);
        or_hold = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
